// File: rtl/psum_reader_if.sv
// rtl/psum_reader_if.sv - psum buffer read port and int8 output stream of psum_reader
//
// Ports (master = psum_reader side):
//   buf_rd_en  master->slave  psum buffer read strobe
//   buf_addr   master->slave  psum buffer read address, ADDR_WIDTH bits
//   buf_data   slave->master  read data, valid the cycle after buf_rd_en
//   out_valid  master->slave  output beat valid
//   out_ready  slave->master  downstream accepts the beat
//   out_data   master->slave  ARRAY_DIM signed int8 lanes, lane c at [c*8 +: 8]
//   out_last   master->slave  final beat of the frame
interface psum_reader_if #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                           buf_rd_en;
    logic [ADDR_WIDTH-1:0]          buf_addr;
    logic [ARRAY_DIM*ACC_WIDTH-1:0] buf_data;
    logic                           out_valid;
    logic                           out_ready;
    logic [ARRAY_DIM*8-1:0]         out_data;
    logic                           out_last;

    modport master (
        output buf_rd_en, buf_addr,
        input  buf_data,
        output out_valid, out_data, out_last,
        input  out_ready
    );

    modport slave (
        input  buf_rd_en, buf_addr,
        output buf_data,
        input  out_valid, out_data, out_last,
        output out_ready
    );
endinterface

// File: rtl/psum_reader.sv
// rtl/psum_reader.sv - drains one frame of partial sums, requantizes to int8 and streams it out
//
// Ports:
//   clk, rst          clock; asynchronous active-high reset
//   start             one-cycle request to drain a frame (ignored unless idle)
//   input_w           input row pitch used for buffer addressing
//   out_h, out_w      output frame height and width
//   shift             requantization right-shift, 0..31
//   busy              high while a frame is being drained
//   done              one-cycle pulse at frame completion
//   bus               psum_reader_if.master: buffer read port and output stream
//
// Build option: define PSUM_READER_RELU_EN to clamp negative results to 0.
module psum_reader #(
    parameter int ARRAY_DIM  = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  input_w,
    input  logic [7:0]  out_h,
    input  logic [7:0]  out_w,
    input  logic [4:0]  shift,
    output logic        busy,
    output logic        done,
    psum_reader_if.master bus
);
    localparam int EXT_W = ACC_WIDTH + 1;
    localparam int OUT_W = ARRAY_DIM * 8;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
    state_t state;

    logic [7:0]            input_w_q;
    logic [7:0]            out_h_q;
    logic [7:0]            out_w_q;
    logic [4:0]            shift_q;
    logic [7:0]            ox;
    logic [7:0]            oy;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] rd_addr;

    // Read issued last cycle; its data is on buf_data this cycle.
    logic                  pend_valid;
    logic                  pend_last;

    logic [OUT_W-1:0]      fifo_data [2];
    logic [1:0]            fifo_last;
    logic                  fifo_wr_ptr;
    logic                  fifo_rd_ptr;
    logic [1:0]            fifo_count;

    logic                  push;
    logic                  pop;
    logic                  issue;
    logic                  row_end;
    logic                  last_coord;
    logic [OUT_W-1:0]      push_data;

    // Round-half-up arithmetic shift in ACC_WIDTH+1 bits so the rounding
    // addend can never overflow, then clamp to the int8 range.
    function automatic logic [7:0] requant(input logic signed [ACC_WIDTH-1:0] psum,
                                           input logic [4:0] sh);
        logic signed [EXT_W-1:0] rnd;
        logic signed [EXT_W-1:0] acc;
        logic signed [EXT_W-1:0] res;
        rnd = (sh == 5'd0) ? '0 : (EXT_W'(1) << (sh - 5'd1));
        acc = EXT_W'(psum) + rnd;
        res = acc >>> sh;
`ifdef PSUM_READER_RELU_EN
        if (res < EXT_W'(0))
            return 8'h00;
`endif
        if (res > EXT_W'(127))
            return 8'h7F;
        if (res < EXT_W'(-128))
            return 8'h80;
        return res[7:0];
    endfunction

    assign row_end    = (ox == out_w_q - 8'd1);
    assign last_coord = row_end && (oy == out_h_q - 8'd1);

    assign push = pend_valid;
    assign pop  = bus.out_valid && bus.out_ready;

    // Entries still held after this cycle's pop, plus the read whose data
    // lands this cycle, must leave one slot for a read issued now. Counting
    // the pop lets the stream run at one beat per cycle under full ready
    // while a stalled consumer can never overflow the two entries.
    assign issue = (state == RUN) &&
                   ((fifo_count + {1'b0, pend_valid} - {1'b0, pop}) < 2'd2);

    assign bus.buf_rd_en = issue;
    assign bus.buf_addr  = rd_addr;

    assign bus.out_valid = (fifo_count != 2'd0);
    assign bus.out_data  = fifo_data[fifo_rd_ptr];
    assign bus.out_last  = bus.out_valid && fifo_last[fifo_rd_ptr];

    // Requantize on the way into the FIFO so the head is already int8.
    always_comb begin
        push_data = '0;
        for (int c = 0; c < ARRAY_DIM; c++)
            push_data[c*8 +: 8] = requant(bus.buf_data[c*ACC_WIDTH +: ACC_WIDTH], shift_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fifo_data[0] <= '0;
            fifo_data[1] <= '0;
            fifo_last    <= '0;
            fifo_wr_ptr  <= 1'b0;
            fifo_rd_ptr  <= 1'b0;
            fifo_count   <= 2'd0;
            pend_valid   <= 1'b0;
            pend_last    <= 1'b0;
        end else begin
            pend_valid <= issue;
            pend_last  <= issue && last_coord;
            if (push) begin
                fifo_data[fifo_wr_ptr] <= push_data;
                fifo_last[fifo_wr_ptr] <= pend_last;
                fifo_wr_ptr            <= ~fifo_wr_ptr;
            end
            if (pop)
                fifo_rd_ptr <= ~fifo_rd_ptr;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 2'd1;
                2'b01:   fifo_count <= fifo_count - 2'd1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            input_w_q <= '0;
            out_h_q   <= '0;
            out_w_q   <= '0;
            shift_q   <= '0;
            ox        <= '0;
            oy        <= '0;
            row_base  <= '0;
            rd_addr   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        input_w_q <= input_w;
                        out_h_q   <= out_h;
                        out_w_q   <= out_w;
                        shift_q   <= shift;
                        ox        <= '0;
                        oy        <= '0;
                        row_base  <= '0;
                        rd_addr   <= '0;
                        if (out_h == 8'd0 || out_w == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (row_end) begin
                            // Row base advances by the pitch; no multiplier needed.
                            ox       <= '0;
                            oy       <= oy + 8'd1;
                            row_base <= row_base + ADDR_WIDTH'(input_w_q);
                            rd_addr  <= row_base + ADDR_WIDTH'(input_w_q);
                            if (last_coord) begin
                                state   <= FLUSH;
                                rd_addr <= '0;
                            end
                        end else begin
                            ox      <= ox + 8'd1;
                            rd_addr <= rd_addr + ADDR_WIDTH'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (pop && bus.out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
